// File: rtl/gayle_sector_feeder.sv
// Host-side sector transfer engine between the host word port and the Gayle sector FIFO.
// Optional feature: define GAYLE_SECTOR_SUM_EN to build the per-sector 16-bit checksum.
module gayle_sector_feeder #(
  parameter int MAX_AHEAD = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk7_en,
  input  logic        cmd_valid,
  input  logic        cmd_dir,
  input  logic [7:0]  cmd_sectors,
  input  logic        abort,
  input  logic [15:0] h_wdata,
  input  logic        h_wr,
  output logic        h_ready,
  output logic [15:0] h_rdata,
  output logic        h_rvalid,
  input  logic        h_rd,
  output logic [15:0] fifo_din,
  output logic        fifo_fast_wr,
  output logic        fifo_fast_rd,
  input  logic [15:0] fifo_dout,
  input  logic        fifo_full,
  input  logic        fifo_last,
  output logic        busy,
  output logic        sector_irq,
  output logic        done,
  output logic [15:0] sum_out,
  output logic [2:0]  o_dbg_state
);

  // Handshake: a host word moves on a cycle where h_wr & h_ready (fill) or
  // h_rd & h_rvalid (drain); ready/valid never depend on the strobes.

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FILL       = 3'd1,
    S_DRAIN_WAIT = 3'd2,
    S_DRAIN      = 3'd3,
    S_DRAIN_BUB  = 3'd4,
    S_FINISH     = 3'd5
  } state_t;

  localparam logic [3:0] LP_MAX_AHEAD = 4'(MAX_AHEAD);

  state_t      r_state;
  state_t      w_next_state;
  logic [8:0]  r_sec_left;
  logic [7:0]  r_word_cnt;
  logic [3:0]  r_pending;
  logic        r_irq;
  logic        r_done;

  logic        w_start;
  logic        w_fill_ready;
  logic        w_wr_fire;
  logic        w_rd_fire;
  logic        w_wrap;
  logic        w_pend_inc;
  logic        w_pend_dec;
  logic        w_unused;

  // clk7_en is not needed: fifo_last arrives already qualified.
  assign w_unused = clk7_en;

  assign w_start      = (r_state == S_IDLE) & cmd_valid & ~abort;
  assign w_fill_ready = (r_pending < LP_MAX_AHEAD) & (r_sec_left != 9'd0);
  assign w_wr_fire    = (r_state == S_FILL) & h_wr & w_fill_ready & ~abort;
  assign w_rd_fire    = (r_state == S_DRAIN) & h_rd & ~abort;
  assign w_wrap       = (w_wr_fire | w_rd_fire) & (r_word_cnt == 8'hFF);
  assign w_pend_inc   = w_wrap & (r_state == S_FILL);
  assign w_pend_dec   = fifo_last & (r_state == S_FILL) & (r_pending != 4'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_next_state = cmd_dir ? S_DRAIN_WAIT : S_FILL;
        end
      end
      S_FILL: begin
        if ((r_sec_left == 9'd0) && (r_pending == 4'd0)) begin
          w_next_state = S_FINISH;
        end
      end
      S_DRAIN_WAIT: begin
        if (fifo_full) begin
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_rd_fire) begin
          if (w_wrap) begin
            w_next_state = (r_sec_left == 9'd1) ? S_FINISH : S_DRAIN_WAIT;
          end else begin
            w_next_state = S_DRAIN_BUB;
          end
        end
      end
      S_DRAIN_BUB: w_next_state = S_DRAIN;
      S_FINISH:    w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
    if (abort) begin
      w_next_state = S_IDLE;
    end
  end

  always_comb begin
    h_ready      = 1'b0;
    h_rvalid     = 1'b0;
    fifo_fast_wr = 1'b0;
    fifo_fast_rd = 1'b0;
    fifo_din     = 16'h0000;
    h_rdata      = fifo_dout;
    busy         = (r_state != S_IDLE);
    sector_irq   = r_irq;
    done         = r_done;
    o_dbg_state  = r_state;
    case (r_state)
      S_FILL: begin
        h_ready      = w_fill_ready;
        fifo_fast_wr = w_wr_fire;
        fifo_din     = w_wr_fire ? h_wdata : 16'h0000;
      end
      S_DRAIN: begin
        h_rvalid     = 1'b1;
        fifo_fast_rd = w_rd_fire;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sec_left <= 9'd0;
      r_word_cnt <= 8'd0;
      r_pending  <= 4'd0;
      r_irq      <= 1'b0;
      r_done     <= 1'b0;
    end else if (abort) begin
      r_word_cnt <= 8'd0;
      r_pending  <= 4'd0;
      r_irq      <= 1'b0;
    end else if (w_start) begin
      r_sec_left <= (cmd_sectors == 8'd0) ? 9'd256 : {1'b0, cmd_sectors};
      r_word_cnt <= 8'd0;
      r_pending  <= 4'd0;
      r_irq      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_irq <= w_wrap;
      if (w_wr_fire || w_rd_fire) begin
        r_word_cnt <= r_word_cnt + 8'd1;
      end
      if (w_wrap) begin
        r_sec_left <= r_sec_left - 9'd1;
      end
      // An Amiga-side sector completion cancels a simultaneous host-side one.
      if (w_pend_inc && !w_pend_dec) begin
        r_pending <= r_pending + 4'd1;
      end else if (w_pend_dec && !w_pend_inc) begin
        r_pending <= r_pending - 4'd1;
      end
      if (r_state == S_FINISH) begin
        r_done <= 1'b1;
      end
    end
  end

`ifdef GAYLE_SECTOR_SUM_EN
  logic [15:0] r_acc;
  logic [15:0] r_sum;
  logic [15:0] w_word;

  assign w_word  = (r_state == S_FILL) ? h_wdata : fifo_dout;
  assign sum_out = r_sum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= 16'h0000;
      r_sum <= 16'h0000;
    end else if (abort || w_start) begin
      r_acc <= 16'h0000;
    end else if (w_wr_fire || w_rd_fire) begin
      if (w_wrap) begin
        r_sum <= r_acc + w_word;
        r_acc <= 16'h0000;
      end else begin
        r_acc <= r_acc + w_word;
      end
    end
  end
`else
  assign sum_out = 16'h0000;
`endif

endmodule

// File: tb/tb_gayle_sector_feeder.sv
// Directed bench for gayle_sector_feeder: fill, flow control, drain, stall, 256-sector, abort, reset.
`define CHK(tag, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      errors++; \
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); \
    end \
  end

module tb_gayle_sector_feeder;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk7_en = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_dir = 1'b0;
  logic [7:0]  cmd_sectors = 8'd0;
  logic        abort = 1'b0;
  logic [15:0] h_wdata = 16'h0000;
  logic        h_wr = 1'b0;
  logic        h_ready;
  logic [15:0] h_rdata;
  logic        h_rvalid;
  logic        h_rd = 1'b0;
  logic [15:0] fifo_din;
  logic        fifo_fast_wr;
  logic        fifo_fast_rd;
  logic [15:0] fifo_dout = 16'hA5C3;
  logic        fifo_full = 1'b0;
  logic        fifo_last = 1'b0;
  logic        busy;
  logic        sector_irq;
  logic        done;
  logic [15:0] sum_out;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int n_wr = 0;
  int n_rd = 0;
  int n_irq = 0;
  int b_wr, b_rd, b_irq, bad;
  logic ok;
  logic [15:0] exp_sum;

  gayle_sector_feeder #(.MAX_AHEAD(2)) dut (
    .clk(clk), .reset_n(reset_n), .clk7_en(clk7_en),
    .cmd_valid(cmd_valid), .cmd_dir(cmd_dir), .cmd_sectors(cmd_sectors), .abort(abort),
    .h_wdata(h_wdata), .h_wr(h_wr), .h_ready(h_ready),
    .h_rdata(h_rdata), .h_rvalid(h_rvalid), .h_rd(h_rd),
    .fifo_din(fifo_din), .fifo_fast_wr(fifo_fast_wr), .fifo_fast_rd(fifo_fast_rd),
    .fifo_dout(fifo_dout), .fifo_full(fifo_full), .fifo_last(fifo_last),
    .busy(busy), .sector_irq(sector_irq), .done(done), .sum_out(sum_out),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) clk7_en <= ~clk7_en;

  // strobe tallies sampled on the active edge
  always @(posedge clk) begin
    if (fifo_fast_wr) n_wr++;
    if (fifo_fast_rd) n_rd++;
    if (sector_irq)   n_irq++;
  end

  task automatic snap();
    b_wr = n_wr; b_rd = n_rd; b_irq = n_irq;
  endtask

  task automatic issue_cmd(input logic dir, input logic [7:0] secs);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dir = dir; cmd_sectors = secs;
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
  endtask

  task automatic pulse_last();
    @(negedge clk); fifo_last = 1'b1;
    @(negedge clk); fifo_last = 1'b0;
  endtask

  task automatic wait_done(input int limit, output logic hit);
    hit = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk); #1;
      if (done) begin
        hit = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    // reset values, strobes requested but must stay low
    h_wr = 1'b1; h_rd = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    `CHK("rst_busy", busy, 1'b0)
    `CHK("rst_h_ready", h_ready, 1'b0)
    `CHK("rst_h_rvalid", h_rvalid, 1'b0)
    `CHK("rst_wr", fifo_fast_wr, 1'b0)
    `CHK("rst_rd", fifo_fast_rd, 1'b0)
    `CHK("rst_irq", sector_irq, 1'b0)
    `CHK("rst_done", done, 1'b0)
    `CHK("rst_sum", sum_out, 16'h0000)
    `CHK("rst_din", fifo_din, 16'h0000)
    `CHK("rst_rdata", h_rdata, 16'hA5C3)
    h_wr = 1'b0; h_rd = 1'b0;
    @(negedge clk); reset_n = 1'b1;

    // fill one sector 0x0000..0x00FF back-to-back
    snap();
    issue_cmd(1'b0, 8'd1);
    `CHK("f1_busy", busy, 1'b1)
    `CHK("f1_ready", h_ready, 1'b1)
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge clk);
      h_wr = 1'b1; h_wdata = 16'(i);
      #1;
      if (!(fifo_fast_wr === 1'b1 && fifo_din === 16'(i))) bad++;
    end
    @(negedge clk); h_wr = 1'b0; #1;
    `CHK("f1_words", bad, 0)
    `CHK("f1_irq", sector_irq, 1'b1)
`ifdef GAYLE_SECTOR_SUM_EN
    exp_sum = 16'h7F80;
`else
    exp_sum = 16'h0000;
`endif
    `CHK("f1_sum", sum_out, exp_sum)
    `CHK("f1_ready_end", h_ready, 1'b0)
    `CHK("f1_nwr", n_wr - b_wr, 256)
    `CHK("f1_done_early", done, 1'b0)
    pulse_last();
    wait_done(10, ok);
    `CHK("f1_done", ok, 1'b1)
    `CHK("f1_idle", busy, 1'b0)
    `CHK("f1_nirq", n_irq - b_irq, 1)

    // flow control: 4 sectors, Amiga not reading
    snap();
    issue_cmd(1'b0, 8'd4);
    `CHK("fc_done_clr", done, 1'b0)
    h_wr = 1'b1;
    repeat (520) begin
      @(negedge clk); h_wdata = 16'($urandom_range(0, 65535));
    end
    #1;
    `CHK("fc_nwr512", n_wr - b_wr, 512)
    `CHK("fc_ready_lo", h_ready, 1'b0)
    pulse_last();
    #1;
    `CHK("fc_ready_back", h_ready, 1'b1)
    repeat (300) @(negedge clk);
    #1;
    `CHK("fc_nwr768", n_wr - b_wr, 768)
    `CHK("fc_done_768", done, 1'b0)
    pulse_last();
    repeat (300) @(negedge clk);
    #1;
    `CHK("fc_nwr1024", n_wr - b_wr, 1024)
    `CHK("fc_nirq4", n_irq - b_irq, 4)
    h_wr = 1'b0;
    pulse_last();
    repeat (4) @(negedge clk);
    #1;
    `CHK("fc_done_3last", done, 1'b0)
    `CHK("fc_busy_3last", busy, 1'b1)
    pulse_last();
    wait_done(10, ok);
    `CHK("fc_done", ok, 1'b1)
    `CHK("fc_nwr_final", n_wr - b_wr, 1024)

    // drain 2 sectors, FIFO always full, host always popping
    fifo_dout = 16'h1234; fifo_full = 1'b1; h_rd = 1'b1;
    snap();
    issue_cmd(1'b1, 8'd2);
    `CHK("dr_wait_rvalid", h_rvalid, 1'b0)
    `CHK("dr_done_clr", done, 1'b0)
    @(negedge clk); #1;
    `CHK("dr_rvalid1", h_rvalid, 1'b1)
    `CHK("dr_rdata", h_rdata, 16'h1234)
    `CHK("dr_rd1", fifo_fast_rd, 1'b1)
    @(negedge clk); #1;
    `CHK("dr_bubble", h_rvalid, 1'b0)
    `CHK("dr_bubble_rd", fifo_fast_rd, 1'b0)
    @(negedge clk); #1;
    `CHK("dr_rvalid2", h_rvalid, 1'b1)
    wait_done(1200, ok);
    `CHK("dr_done", ok, 1'b1)
    `CHK("dr_nrd", n_rd - b_rd, 512)
    `CHK("dr_nirq", n_irq - b_irq, 2)

    // drain stall after the first sector
    snap();
    issue_cmd(1'b1, 8'd2);
    ok = 1'b0;
    for (int k = 0; k < 700; k++) begin
      @(negedge clk); #1;
      if (sector_irq) begin
        ok = 1'b1;
        break;
      end
    end
    `CHK("st_irq1", ok, 1'b1)
    fifo_full = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    `CHK("st_rvalid", h_rvalid, 1'b0)
    `CHK("st_busy", busy, 1'b1)
    `CHK("st_nrd", n_rd - b_rd, 256)
    fifo_full = 1'b1;
    wait_done(700, ok);
    `CHK("st_done", ok, 1'b1)
    `CHK("st_nrd_final", n_rd - b_rd, 512)
    `CHK("st_nirq", n_irq - b_irq, 2)
    fifo_full = 1'b0; h_rd = 1'b0;

    // sector count 0 means 256 sectors; Amiga acknowledges each sector at once
    snap();
    issue_cmd(1'b0, 8'd0);
    h_wr = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 70000; k++) begin
      @(negedge clk);
      fifo_last = sector_irq;
      #1;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    h_wr = 1'b0; fifo_last = 1'b0;
    `CHK("z_done", ok, 1'b1)
    `CHK("z_nwr", n_wr - b_wr, 65536)
    `CHK("z_nirq", n_irq - b_irq, 256)

    // abort at word 100 of a fill
    snap();
    issue_cmd(1'b0, 8'd1);
    h_wr = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i > 0) @(negedge clk);
      h_wdata = 16'(i);
    end
    @(negedge clk); abort = 1'b1; #1;
    `CHK("ab_no_strobe", fifo_fast_wr, 1'b0)
    @(negedge clk); abort = 1'b0; #1;
    `CHK("ab_busy", busy, 1'b0)
    `CHK("ab_done", done, 1'b0)
    `CHK("ab_ready", h_ready, 1'b0)
    repeat (10) @(negedge clk);
    #1;
    `CHK("ab_nwr", n_wr - b_wr, 100)
    h_wr = 1'b0;

    // asynchronous reset in the middle of a drain
    fifo_full = 1'b1; h_rd = 1'b1;
    issue_cmd(1'b1, 8'd1);
    repeat (50) @(negedge clk);
    reset_n = 1'b0;
    #1;
    `CHK("rm_busy", busy, 1'b0)
    `CHK("rm_rvalid", h_rvalid, 1'b0)
    `CHK("rm_rd", fifo_fast_rd, 1'b0)
    `CHK("rm_irq", sector_irq, 1'b0)
    `CHK("rm_done", done, 1'b0)
    `CHK("rm_sum", sum_out, 16'h0000)
    @(negedge clk); reset_n = 1'b1; h_rd = 1'b0; fifo_full = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
